// File: rtl/puf_host_link_if.sv
// Host-side request/response bundle for puf_host_link: one challenge in, one
// response frame plus status out.
interface puf_host_link_if #(
   parameter int REG_BIT_SIZE = 8,
   parameter int DEBUG_MOD    = 133
);
   logic                    req_valid;
   logic                    req_ready;
   logic [REG_BIT_SIZE-1:0] req_chal;
   logic                    req_mode;
   logic                    rsp_valid;
   logic [DEBUG_MOD-1:0]    rsp_data;
   logic                    rsp_err;

   modport master (
      output req_valid, req_chal, req_mode,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  req_valid, req_chal, req_mode,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/puf_host_link.sv
// Host-side driver for the puf_soc_top serial link: sends a challenge LSB-first,
// then collects the response frame LSB-first into one parallel word.
module puf_host_link #(
   parameter int REG_BIT_SIZE = 8,
   parameter int NORM_MOD     = 34,
   parameter int DEBUG_MOD    = 133,
   parameter int TIMEOUT      = 1024
) (
   input  logic           clk,
   input  logic           rst_n,
   puf_host_link_if.slave host,
   output logic           o_busy,
   output logic           o_start,
   output logic           o_op_mode,
   input  logic           i_soc_rx_ready,
   output logic           o_soc_rx_valid,
   output logic           o_soc_rx_data,
   output logic           o_soc_tx_ready,
   input  logic           i_soc_tx_valid,
   input  logic           i_soc_tx_data
);
   localparam int IDX_W = $clog2(DEBUG_MOD + 1);
   localparam int TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [IDX_W-1:0] SEND_LAST = IDX_W'(REG_BIT_SIZE - 1);
   localparam logic [IDX_W-1:0] NORM_LAST = IDX_W'(NORM_MOD - 1);
   localparam logic [IDX_W-1:0] DBG_LAST  = IDX_W'(DEBUG_MOD - 1);
   localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_SEND  = 3'd2,
      ST_RECV  = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   state_e                  state_q, state_d;
   logic [REG_BIT_SIZE-1:0] chal_q, chal_d;
   logic                    mode_q, mode_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d, tmo_inc;
   logic                    err_q, err_d;
   logic [DEBUG_MOD-1:0]    rsp_data_q, rsp_data_d;
   logic                    req_ready_q, req_ready_d;
   logic                    busy_q, busy_d;
   logic                    start_q, start_d;
   logic                    op_mode_q, op_mode_d;
   logic                    rx_valid_q, rx_valid_d;
   logic                    rx_data_q, rx_data_d;
   logic                    tx_ready_q, tx_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_err_q, rsp_err_d;

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d    = state_q;
      chal_d     = chal_q;
      mode_d     = mode_q;
      idx_d      = idx_q;
      tmo_d      = tmo_q;
      err_d      = err_q;
      rsp_data_d = rsp_data_q;
      tmo_inc    = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (host.req_valid && req_ready_q) begin
               chal_d     = host.req_chal;
               mode_d     = host.req_mode;
               idx_d      = '0;
               tmo_d      = '0;
               err_d      = 1'b0;
               rsp_data_d = '0;
               state_d    = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            state_d = ST_SEND;
         end
         ST_SEND: begin
            // The challenge is kept as a shift register so bit 0 is always the one on the wire.
            if (rx_valid_q && i_soc_rx_ready) begin
               chal_d = chal_q >> 1;
               tmo_d  = '0;
               if (idx_q == SEND_LAST) begin
                  idx_d   = '0;
                  state_d = ST_RECV;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TMO_MAX) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SEND;
               end
            end
         end
         ST_RECV: begin
            if (tx_ready_q && i_soc_tx_valid) begin
               rsp_data_d = rsp_data_q | (DEBUG_MOD'(i_soc_tx_data) << idx_q);
               tmo_d      = '0;
               idx_d      = idx_q + IDX_W'(1);
               if (idx_q == (mode_q ? DBG_LAST : NORM_LAST)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RECV;
               end
            end else begin
               tmo_d = tmo_inc;
               if (tmo_inc == TMO_MAX) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_RECV;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      start_d     = (state_d == ST_START);
      op_mode_d   = ((state_d == ST_START) || (state_d == ST_SEND) || (state_d == ST_RECV))
                    ? mode_d : 1'b0;
      rx_valid_d  = (state_d == ST_SEND);
      rx_data_d   = (state_d == ST_SEND) ? chal_d[0] : 1'b0;
      tx_ready_d  = (state_d == ST_RECV);
      rsp_valid_d = (state_d == ST_DONE);
      rsp_err_d   = (state_d == ST_DONE) && err_d;
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         chal_q      <= '0;
         mode_q      <= 1'b0;
         idx_q       <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         rsp_data_q  <= '0;
         req_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         op_mode_q   <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 1'b0;
         tx_ready_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         chal_q      <= chal_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         rsp_data_q  <= rsp_data_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         op_mode_q   <= op_mode_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
         tx_ready_q  <= tx_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign host.req_ready = req_ready_q;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_data  = rsp_data_q;
   assign host.rsp_err   = rsp_err_q;
   assign o_busy         = busy_q;
   assign o_start        = start_q;
   assign o_op_mode      = op_mode_q;
   assign o_soc_rx_valid = rx_valid_q;
   assign o_soc_rx_data  = rx_data_q;
   assign o_soc_tx_ready = tx_ready_q;
endmodule

// File: tb/tb_puf_host_link.sv
// Directed + randomized bench for puf_host_link; the SoC side is modelled here and
// the expected frame is derived from the bits the bench itself sent.
module tb_puf_host_link;
   localparam int RB = 8;
   localparam int NM = 34;
   localparam int DM = 133;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic i_soc_rx_ready = 1'b0;
   logic i_soc_tx_valid = 1'b0;
   logic i_soc_tx_data  = 1'b0;
   logic o_busy, o_start, o_op_mode, o_soc_rx_valid, o_soc_rx_data, o_soc_tx_ready;

   int total  = 0;
   int passed = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   puf_host_link_if #(.REG_BIT_SIZE(RB), .DEBUG_MOD(DM)) hif ();

   puf_host_link #(.REG_BIT_SIZE(RB), .NORM_MOD(NM), .DEBUG_MOD(DM), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .host           (hif),
      .o_busy         (o_busy),
      .o_start        (o_start),
      .o_op_mode      (o_op_mode),
      .i_soc_rx_ready (i_soc_rx_ready),
      .o_soc_rx_valid (o_soc_rx_valid),
      .o_soc_rx_data  (o_soc_rx_data),
      .o_soc_tx_ready (o_soc_tx_ready),
      .i_soc_tx_valid (i_soc_tx_valid),
      .i_soc_tx_data  (i_soc_tx_data)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chkv(input string tag, input logic [DM-1:0] obs, input logic [DM-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference: the response word is simply the first n bits the SoC handed over.
   function automatic logic [DM-1:0] expect_rsp(input logic [DM-1:0] frame, input int n);
      logic [DM-1:0] r;
      r = '0;
      for (int k = 0; k < n; k++) r[k] = frame[k];
      return r;
   endfunction

   function automatic int flen(input logic mode);
      return mode ? DM : NM;
   endfunction

   function automatic logic [DM-1:0] rand_frame();
      logic [DM-1:0] f;
      for (int k = 0; k < DM; k++) f[k] = 1'($urandom_range(0, 1));
      return f;
   endfunction

   task automatic accept(input logic [RB-1:0] chal, input logic mode);
      int n;
      n = 0;
      while (hif.req_ready !== 1'b1 && n < 50) begin
         cyc();
         n++;
      end
      chk1("req_ready_idle", hif.req_ready, 1'b1);
      hif.req_valid = 1'b1;
      hif.req_chal  = chal;
      hif.req_mode  = mode;
      cyc();
      hif.req_valid = 1'b0;
      chk1("start_pulse", o_start, 1'b1);
      chk1("busy_start", o_busy, 1'b1);
      chk1("req_ready_busy", hif.req_ready, 1'b0);
      chk1("op_mode_start", o_op_mode, mode);
      chk1("rx_valid_early", o_soc_rx_valid, 1'b0);
      chkv("rsp_data_cleared", hif.rsp_data, '0);
      cyc();
      chk1("start_once", o_start, 1'b0);
      chk1("rx_valid_first", o_soc_rx_valid, 1'b1);
   endtask

   task automatic send_phase(input logic [RB-1:0] chal, input int stall_at, input int stall_len,
                             output logic [RB-1:0] got);
      int nb, cyc_n, stalled;
      logic v, d, r;
      nb = 0; cyc_n = 0; stalled = 0; got = '0;
      while (nb < RB && cyc_n < 200) begin
         v = o_soc_rx_valid;
         d = o_soc_rx_data;
         chk1("rx_valid_send", v, 1'b1);
         chk1("rx_data_bit", d, chal[nb]);
         chk1("tx_ready_send", o_soc_tx_ready, 1'b0);
         r = !(nb == stall_at && stalled < stall_len);
         if (!r) stalled++;
         i_soc_rx_ready = r;
         i_soc_tx_valid = 1'b1;
         i_soc_tx_data  = 1'($urandom_range(0, 1));
         @(posedge clk);
         if (v && r) begin
            got[nb] = d;
            nb++;
         end
         #1;
         cyc_n++;
      end
      i_soc_rx_ready = 1'b0;
      i_soc_tx_valid = 1'b0;
      chki("send_bits", nb, RB);
      chki("send_cycles", cyc_n, RB + stall_len);
      chk1("rx_valid_drop", o_soc_rx_valid, 1'b0);
      chk1("tx_ready_recv", o_soc_tx_ready, 1'b1);
   endtask

   task automatic recv_phase(input logic [DM-1:0] frame, input int nsend, input int gap_mode,
                             input logic mode);
      int cnt, cyc_n, idle;
      logic v;
      cnt = 0; cyc_n = 0; idle = 0;
      while (cnt < nsend && cyc_n < 1000) begin
         chk1("tx_ready_loop", o_soc_tx_ready, 1'b1);
         chk1("op_mode_recv", o_op_mode, mode);
         case (gap_mode)
            0:       v = 1'b1;
            1:       v = (cyc_n % 2 == 0);
            default: v = (idle >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
         endcase
         idle = v ? 0 : idle + 1;
         i_soc_tx_valid = v;
         i_soc_tx_data  = v ? frame[cnt] : 1'($urandom_range(0, 1));
         @(posedge clk);
         if (v) cnt++;
         #1;
         cyc_n++;
      end
      i_soc_tx_valid = 1'b0;
      i_soc_tx_data  = 1'b0;
      chki("recv_sent", cnt, nsend);
   endtask

   task automatic wait_rsp(input logic [DM-1:0] exp_data, input logic exp_err, input int exp_edges);
      int e;
      e = 0;
      while (hif.rsp_valid !== 1'b1 && e < 100) begin
         cyc();
         e++;
      end
      chk1("rsp_valid", hif.rsp_valid, 1'b1);
      chki("rsp_latency", e, exp_edges);
      chk1("rsp_err", hif.rsp_err, exp_err);
      chkv("rsp_data", hif.rsp_data, exp_data);
      chk1("tx_ready_done", o_soc_tx_ready, 1'b0);
      cyc();
      chk1("rsp_pulse_end", hif.rsp_valid, 1'b0);
      chkv("rsp_data_hold", hif.rsp_data, exp_data);
      chk1("busy_idle", o_busy, 1'b0);
      chk1("op_mode_idle", o_op_mode, 1'b0);
      chk1("req_ready_after", hif.req_ready, 1'b1);
   endtask

   task automatic run_txn(input logic [RB-1:0] chal, input logic mode, input logic [DM-1:0] frame,
                          input int nsend, input int gap_mode, input int stall_at, input int stall_len);
      logic [RB-1:0] got;
      int n;
      accept(chal, mode);
      send_phase(chal, stall_at, stall_len, got);
      chki("send_byte", int'(got), int'(chal));
      recv_phase(frame, nsend, gap_mode, mode);
      n = (nsend < flen(mode)) ? nsend : flen(mode);
      wait_rsp(expect_rsp(frame, n), nsend < flen(mode), (nsend < flen(mode)) ? TO : 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DM-1:0] frame, frame2;
      logic [33:0]   beef;
      logic [RB-1:0] c1, c2, got;

      hif.req_valid = 1'b0;
      hif.req_chal  = '0;
      hif.req_mode  = 1'b0;
      cyc();
      cyc();
      chk1("rst_req_ready", hif.req_ready, 1'b1);
      chk1("rst_busy", o_busy, 1'b0);
      chk1("rst_start", o_start, 1'b0);
      chk1("rst_rx_valid", o_soc_rx_valid, 1'b0);
      chk1("rst_tx_ready", o_soc_tx_ready, 1'b0);
      chk1("rst_rsp_valid", hif.rsp_valid, 1'b0);
      chkv("rst_rsp_data", hif.rsp_data, '0);
      rst_n = 1'b1;
      cyc();

      // Directed normal transaction with the known 34-bit pattern.
      beef  = 34'h2DEADBEEF;
      frame = '0;
      frame[33:0] = beef;
      run_txn(8'hA5, 1'b0, frame, NM, 0, 99, 0);

      // Ready stall of 3 cycles while bit 2 is on the wire.
      run_txn(8'($urandom_range(0, 255)), 1'b0, rand_frame(), NM, 0, 2, 3);

      // Debug frame with tx_valid on every other cycle.
      run_txn(8'($urandom_range(0, 255)), 1'b1, rand_frame(), DM, 1, 99, 0);

      // SoC stops after 10 response bits.
      run_txn(8'($urandom_range(0, 255)), 1'b0, rand_frame(), 10, 0, 99, 0);

      // Reset in the middle of RECV.
      c1 = 8'($urandom_range(0, 255));
      accept(c1, 1'b0);
      send_phase(c1, 99, 0, got);
      recv_phase(rand_frame(), 20, 0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_req_ready", hif.req_ready, 1'b1);
      chk1("mid_rst_busy", o_busy, 1'b0);
      chk1("mid_rst_tx_ready", o_soc_tx_ready, 1'b0);
      chk1("mid_rst_op_mode", o_op_mode, 1'b0);
      chk1("mid_rst_rsp_valid", hif.rsp_valid, 1'b0);
      chkv("mid_rst_rsp_data", hif.rsp_data, '0);
      cyc();
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk1("no_rsp_after_rst", hif.rsp_valid, 1'b0);
      end
      run_txn(8'($urandom_range(0, 255)), 1'b1, rand_frame(), DM, 0, 99, 0);

      // Request held valid while busy: ignored until the idle cycle after DONE.
      c1 = 8'h3C;
      c2 = 8'hC3;
      frame  = rand_frame();
      frame2 = rand_frame();
      accept(c1, 1'b0);
      hif.req_valid = 1'b1;
      hif.req_chal  = c2;
      hif.req_mode  = 1'b1;
      send_phase(c1, 99, 0, got);
      chki("busy_latched_chal", int'(got), int'(c1));
      chk1("busy_no_ack", hif.req_ready, 1'b0);
      recv_phase(frame, NM, 0, 1'b0);
      wait_rsp(expect_rsp(frame, NM), 1'b0, 0);
      chk1("b2b_not_yet", o_start, 1'b0);
      cyc();
      hif.req_valid = 1'b0;
      chk1("b2b_accept", o_start, 1'b1);
      chk1("b2b_mode", o_op_mode, 1'b1);
      cyc();
      send_phase(c2, 99, 0, got);
      chki("b2b_chal", int'(got), int'(c2));
      recv_phase(frame2, DM, 0, 1'b1);
      wait_rsp(expect_rsp(frame2, DM), 1'b0, 0);

      // Randomized transactions.
      for (int t = 0; t < 6; t++) begin
         logic m;
         m = 1'($urandom_range(0, 1));
         run_txn(8'($urandom_range(0, 255)), m, rand_frame(), flen(m), 2,
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
